// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// master: the side issuing operands and consuming results.
// slave : the multiplier itself.
interface fp_mul_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         exception;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, exception
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, underflow, exception
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754-format floating-point multiplier with a single
// global stall (advance) shared by every stage.
//   S1: unpack operands and classify (zero / Inf / NaN, denormals flushed)
//   S2: mantissa multiply and biased exponent add
//   S3: normalise, optional rounding, saturate and pack with flags
// Define FP_MUL_ROUND_EN for round-to-nearest-even; without it the
// mantissa is truncated toward zero and no rounding logic is built.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic     clk,
    input logic     rst,
    fp_mul_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
`ifdef FP_MUL_ROUND_EN
    // Rounding needs every product bit for guard and sticky.
    localparam int PKW = PW;
`else
    // Truncation only ever looks at the leading MAN_W+2 product bits.
    localparam int PKW = MAN_W + 2;
`endif

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FP_MUL_ROUND_EN
    // Round-to-nearest-even; the MSB of the return value is the carry-out.
    function automatic logic [MAN_W:0] round_rne(
        input logic [MAN_W-1:0] frac,
        input logic             guard,
        input logic             sticky
    );
        logic inc;
        inc = guard & (sticky | frac[0]);
        return {1'b0, frac} + (MAN_W+1)'(inc);
    endfunction
`endif

    // Special-case selection and exponent saturation.
    // Returns {overflow, underflow, exception, result}.
    function automatic logic [W+2:0] sat_pack(
        input logic                 sgn,
        input logic                 nan,
        input logic                 inf,
        input logic                 zero,
        input logic signed [EW-1:0] e,
        input logic [MAN_W-1:0]     f
    );
        logic ovf;
        logic unf;
        ovf = !e[EW-1] && (e >= EXP_MAX);
        unf = e[EW-1] || (e == '0);
        if (nan)
            return {3'b001, QNAN};
        else if (inf)
            return {3'b001, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (zero)
            return {3'b000, sgn, {(W-1){1'b0}}};
        else if (ovf)
            return {3'b100, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf)
            return {3'b010, sgn, {(W-1){1'b0}}};
        else
            return {3'b000, sgn, e[EXP_W-1:0], f};
    endfunction

    // Global flow control: every stage moves together.
    logic advance;
    logic out_valid_q;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;

    // ---------------- S1 inputs: unpack / classify ----------------
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               nan_p1_d, inf_p1_d, zero_p1_d;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;

    // exp==0 covers both true zero and flushed denormals.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    assign nan_p1_d  = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
    assign inf_p1_d  = (a_inf | b_inf) & !nan_p1_d;
    assign zero_p1_d = (a_zero | b_zero) & !nan_p1_d & !inf_p1_d;

    logic               vld_p1_q, vld_p2_q;
    logic               sign_p1_q, nan_p1_q, inf_p1_q, zero_p1_q;
    logic [EXP_W-1:0]   ea_p1_q, eb_p1_q;
    logic [MAN_W:0]     ma_p1_q, mb_p1_q;

    // Stage valid bits; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (advance) begin
            vld_p1_q <= bus.in_valid;
            vld_p2_q <= vld_p1_q;
        end
    end

    // S1 data register: sign, class and operands with hidden bit restored.
    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p1_q <= sa ^ sb;
            nan_p1_q  <= nan_p1_d;
            inf_p1_q  <= inf_p1_d;
            zero_p1_q <= zero_p1_d;
            ea_p1_q   <= ea;
            eb_p1_q   <= eb;
            ma_p1_q   <= {1'b1, fa};
            mb_p1_q   <= {1'b1, fb};
        end
    end

    // ---------------- S2: multiply and exponent add ----------------
    logic [PKW-1:0]        prod_p2_d, prod_p2_q;
    logic signed [EW-1:0]  exp_p2_d, exp_p2_q;
    logic                  sign_p2_q, nan_p2_q, inf_p2_q, zero_p2_q;

    assign prod_p2_d = PKW'((PW'(ma_p1_q) * PW'(mb_p1_q)) >> (PW - PKW));
    assign exp_p2_d  = $signed({2'b00, ea_p1_q}) + $signed({2'b00, eb_p1_q}) - BIAS;

    // S2 data register: raw product and unnormalised biased exponent.
    always_ff @(posedge clk) begin
        if (advance) begin
            prod_p2_q <= prod_p2_d;
            exp_p2_q  <= exp_p2_d;
            sign_p2_q <= sign_p1_q;
            nan_p2_q  <= nan_p1_q;
            inf_p2_q  <= inf_p1_q;
            zero_p2_q <= zero_p1_q;
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic signed [EW-1:0]  exp_n_s3;
    logic signed [EW-1:0]  exp_f_s3;
    logic [MAN_W-1:0]      frac_f_s3;
    logic [W+2:0]          pack_s3;

    // A set product MSB means the mantissa product landed in [2,4).
    assign exp_n_s3 = exp_p2_q + $signed({{(EW-1){1'b0}}, prod_p2_q[PKW-1]});

`ifdef FP_MUL_ROUND_EN
    logic [PKW-2:0] norm_s3;
    logic [MAN_W:0] rnd_s3;

    assign norm_s3   = prod_p2_q[PKW-1] ? prod_p2_q[PKW-2:0] : {prod_p2_q[PKW-3:0], 1'b0};
    assign rnd_s3    = round_rne(norm_s3[PKW-2 -: MAN_W], norm_s3[MAN_W], |norm_s3[MAN_W-1:0]);
    assign frac_f_s3 = rnd_s3[MAN_W-1:0];
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    assign exp_f_s3  = exp_n_s3 + $signed({{(EW-1){1'b0}}, rnd_s3[MAN_W]});
`else
    assign frac_f_s3 = prod_p2_q[PKW-1] ? prod_p2_q[PKW-2:1] : prod_p2_q[PKW-3:0];
    assign exp_f_s3  = exp_n_s3;
`endif

    assign pack_s3 = sat_pack(sign_p2_q, nan_p2_q, inf_p2_q, zero_p2_q, exp_f_s3, frac_f_s3);

    logic [W-1:0] result_d, result_q;
    logic         ovf_d, unf_d, exc_d;
    logic         ovf_q, unf_q, exc_q;

    assign {ovf_d, unf_d, exc_d, result_d} = pack_s3;

    // Output register: result, flags and out_valid cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            exc_q       <= 1'b0;
        end else if (advance) begin
            out_valid_q <= vld_p2_q;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            exc_q       <= exc_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.exception = exc_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (single precision). Stimulus pushes
// hand-computed expected responses; an independent monitor pops and
// compares whenever a result is handed over.
module tb_fp_mul_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct packed {
        logic [31:0] r;
        logic        ovf;
        logic        unf;
        logic        exc;
    } resp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        resp_t       e;
    } vec_t;

    logic clk;
    logic rst;

    fp_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    resp_t sb_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                       input logic ovf, input logic unf, input logic exc);
        vec_t v;
        v.a = a; v.b = b; v.e.r = r; v.e.ovf = ovf; v.e.unf = unf; v.e.exc = exc;
        vecs.push_back(v);
    endtask

    // Present one operand pair until it is accepted (bounded wait).
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input resp_t e, input bit push);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a = va;
        bus.b = vb;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc && push) sb_q.push_back(e);
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, expected 1", bus.in_ready, n);
                acc = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // One pair into an empty pipe; out_valid must rise on the third edge.
    task automatic latency_test(input vec_t v);
        bus.in_valid = 1'b1;
        bus.a = v.a;
        bus.b = v.b;
        @(negedge clk);
        chk("lat_in_ready", 64'(bus.in_ready), 64'd1);
        sb_q.push_back(v.e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("lat_edge1_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge3_out_valid", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_outstanding", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare every handed-over result against the scoreboard.
    initial begin
        resp_t got;
        resp_t want;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got = {bus.result, bus.overflow, bus.underflow, bus.exception};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got r=%h ovf=%b unf=%b exc=%b, expected no output",
                             got.r, got.ovf, got.unf, got.exc);
                end else begin
                    want = sb_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL result: got r=%h ovf=%b unf=%b exc=%b, expected r=%h ovf=%b unf=%b exc=%b",
                                 got.r, got.ovf, got.unf, got.exc, want.r, want.ovf, want.unf, want.exc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;

        add(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
`ifdef FP_MUL_ROUND_EN
        add(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 0);
        add(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 0, 0, 0);
        add(32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 1, 0, 0);
`else
        add(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 0, 0, 0);
        add(32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 0, 0, 0);
        add(32'h7F7FFFFE, 32'h3F800001, 32'h7F7FFFFF, 0, 0, 0);
`endif
        add(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0);
        add(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0);
        add(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1);
        add(32'hFF800000, 32'h00000000, 32'h7FC00000, 0, 0, 1);
        add(32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0);
        add(32'h80000000, 32'h40000000, 32'h80000000, 0, 0, 0);
        add(32'h00000001, 32'h40000000, 32'h00000000, 0, 0, 0);
        add(32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0, 1);
        add(32'hFF800000, 32'hFF800000, 32'h7F800000, 0, 0, 1);
        add(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0);
        add(32'h7F000000, 32'h3F800000, 32'h7F000000, 0, 0, 0);
        add(32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 0);
        add(32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0);
        add(32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0);
        add(32'h80800000, 32'h00800000, 32'h80000000, 0, 1, 0);
        add(32'h7FC00000, 32'h00000000, 32'h7FC00000, 0, 0, 1);

        // Asynchronous reset, asserted before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_flags", 64'({bus.overflow, bus.underflow, bus.exception}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        latency_test(vecs[0]);
        for (int i = 1; i < vecs.size(); i++) send(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
        drain();

        // Back-to-back stream with a 4-cycle consumer stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    resp_t e;
                    e.r = 32'h40400000 + (32'(i) << 23);
                    e.ovf = 1'b0; e.unf = 1'b0; e.exc = 1'b0;
                    send(32'h3F800000 + (32'(i) << 23), 32'h40400000, e, 1'b1);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two pairs in flight: neither may ever be handed over.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(vecs[0].a, vecs[0].b, vecs[0].e, 1'b0);
        send(vecs[8].a, vecs[8].b, vecs[8].e, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        chk("inflight_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_result", 64'(bus.result), 64'd0);
        chk("async_rst_flags", 64'({bus.overflow, bus.underflow, bus.exception}), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_ghost_out_valid", 64'(bus.out_valid), 64'd0);
        end

        // Recovery: first accept after reset still takes exactly 3 edges.
        @(posedge clk);
        #1;
        latency_test(vecs[0]);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width; legal range 5..11.
REQ-002 Parameter MAN_W, default 23: stored mantissa field width, no hidden bit; legal range 10..52.
REQ-003 Local width W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.
REQ-004 Port clk input 1: single clock; all state updates on rising edge.
REQ-005 Port rst input 1: asynchronous, active-high reset.
REQ-006 Port in_valid input 1: operands a, b present.
REQ-007 Port in_ready output 1: block accepts operands this cycle.
REQ-008 Port a input W: IEEE-754-format operand {sign, exp, man}.
REQ-009 Port b input W: second operand, same format.
REQ-010 Port out_valid output 1: result and flags valid.
REQ-011 Port out_ready input 1: consumer accepts the result this cycle.
REQ-012 Port result output W: product.
REQ-013 Port overflow output 1: finite operands produced a product exponent above the maximum finite exponent.
REQ-014 Port underflow output 1: nonzero finite operands produced a product exponent below 1.
REQ-015 Port exception output 1: either operand is NaN or Inf, or the operation is 0*Inf.

Function
REQ-016 The pipeline SHALL have 3 register stages: S1 unpack/classify, S2 mantissa multiply and exponent add, S3 normalise/round/pack. Latency is 3 cycles from the accept edge to out_valid when not stalled.
REQ-017 Global advance = !out_valid || out_ready; in_ready = advance. An operand pair is accepted on an edge where in_valid && in_ready.
REQ-018 While advance = 0, all stages, result and flags SHALL hold unchanged, including through bubbles.
REQ-019 Stage valid bits SHALL propagate bubbles. Throughput is one result per cycle under continuous out_ready.
REQ-020 Sign = a.sign XOR b.sign for every case, including zero, Inf and NaN.
REQ-021 Denormal inputs (exp=0, man≠0) SHALL be treated as signed zero (flush-to-zero).
REQ-022 The product SHALL be (MAN_W+1)x(MAN_W+1) bits wide. If the product MSB is set, shift right by 1 and add 1 to the exponent.
REQ-023 Biased exponent arithmetic SHALL use EXP_W+2 signed bits: ea+eb-BIAS(+1).
REQ-024 If the final exponent ≥ 2^EXP_W-1: result = signed Inf, overflow=1.
REQ-025 If the final exponent ≤ 0 and both operands are nonzero: result = signed zero, underflow=1.
REQ-026 NaN on either input, or 0*Inf: result = quiet NaN {0, all-ones, 1 followed by zeros}, exception=1.
REQ-027 Inf*finite-nonzero or Inf*Inf: result = signed Inf, exception=1, overflow=0.
REQ-028 Zero*finite: result = signed zero, all flags 0.
REQ-029 Flags SHALL be registered alongside result in S3. They are meaningful only while out_valid=1.

Reset
REQ-030 On rst=1, all stage valid bits, out_valid, result, overflow, underflow and exception SHALL clear to 0 immediately, without waiting for clk.
REQ-031 In-flight operations SHALL be discarded by reset. in_ready = 1 during and after reset, since out_valid = 0.
REQ-032 The first accept after rst deasserts SHALL produce out_valid exactly 3 edges later.

Configuration
REQ-033 Macro FP_MUL_ROUND_EN.
- Defined: round-to-nearest-even using guard and sticky bits. A mantissa carry-out SHALL renormalise and increment the exponent, and overflow is re-checked after rounding.
- Undefined: truncate toward zero, with no rounding logic synthesised.

Verification
REQ-034 a=0x40000000, b=0x40400000, in_valid pulse, out_ready=1 -> result=0x40C00000 3 cycles later, flags 0.
REQ-035 a=0x3F800001, b=0x3FC00000 -> result=0x3FC00002 with FP_MUL_ROUND_EN defined; 0x3FC00001 without it.
REQ-036 Overflow and underflow cases:
- a=0x7F000000, b=0x7F000000 -> 0x7F800000, overflow=1.
- a=0x00800000, b=0x00800000 -> 0x00000000, underflow=1.
REQ-037 Exception cases:
- a=0x7FC00000, b=0x3F800000 -> 0x7FC00000, exception=1.
- a=0xFF800000, b=0x00000000 -> 0x7FC00000, exception=1.
REQ-038 Back-to-back stream of 8 pairs with out_ready held 0 for 4 cycles mid-stream -> in_ready=0 during the stall, no loss or duplication, results in order. rst pulsed with 2 pairs in flight -> out_valid=0 immediately and neither pair ever emerges.
